// File: rtl/axi4_to_axis_ipv4_reader.sv
// AXI4 read master that fetches one stored Ethernet/IPv4 frame and replays it on AXI-Stream.
// A single-beat header read supplies the length, then one INCR burst streams the whole frame.
module axi4_to_axis_ipv4_reader #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 512,
  parameter int ID_WIDTH      = 4,
  parameter int ETH_HDR_BYTES = 14,
  parameter int MAX_BEATS     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   pkt_addr,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [15:0]             pkt_bytes,
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast
);
  localparam int BEAT_BYTES = DATA_WIDTH / 8;
  localparam int OFF_BITS   = $clog2(BEAT_BYTES);
  localparam int TL_LSB     = 8 * (ETH_HDR_BYTES + 2);
  localparam logic [BEAT_BYTES-1:0] KEEP_ONES = '1;

  typedef enum logic [2:0] {S_IDLE, S_HDR_AR, S_HDR_R, S_PKT_AR, S_PKT_R, S_DONE} state_e;
  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [15:0]           pkt_bytes_q;
  logic [7:0]            last_cnt_q, cnt_q;
  logic                  rcvd_all_q, err_q;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic [BEAT_BYTES-1:0] tkeep_q;
  logic                  tvalid_q, tlast_q;

  logic                  start_ok, pkt_r_hs, t_hs, is_last_beat, hdr_reject;
  logic [15:0]           hdr_tl;
  logic [16:0]           hdr_bytes, hdr_beats;
  logic [OFF_BITS-1:0]   tail;
  logic [BEAT_BYTES-1:0] keep_last;
  logic                  unused_ok;

  assign start_ok     = start && (state_q == S_IDLE || state_q == S_DONE);
  assign pkt_r_hs     = (state_q == S_PKT_R) && m_axi_rvalid && m_axi_rready;
  assign t_hs         = tvalid_q && m_axis_tready;
  assign is_last_beat = (cnt_q == last_cnt_q);

  // Total length is big-endian in bytes E+2/E+3 of the header beat.
  assign hdr_tl     = {m_axi_rdata[TL_LSB +: 8], m_axi_rdata[TL_LSB+8 +: 8]};
  assign hdr_bytes  = {1'b0, hdr_tl} + 17'(ETH_HDR_BYTES);
  assign hdr_beats  = (hdr_bytes + 17'(BEAT_BYTES - 1)) >> OFF_BITS;
  assign hdr_reject = (hdr_tl < 16'd20) || (hdr_beats > 17'(MAX_BEATS)) || (m_axi_rresp != 2'b00);

  assign tail      = pkt_bytes_q[OFF_BITS-1:0];
  assign keep_last = (tail == '0) ? KEEP_ONES : ~(KEEP_ONES << tail);
  assign unused_ok = ^{m_axi_rid, pkt_addr[OFF_BITS-1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_HDR_AR;
      S_HDR_AR: if (m_axi_arready) state_d = S_HDR_R;
      S_HDR_R:  if (m_axi_rvalid) state_d = hdr_reject ? S_DONE : S_PKT_AR;
      S_PKT_AR: if (m_axi_arready) state_d = S_PKT_R;
      S_PKT_R:  if (t_hs && tlast_q) state_d = S_DONE;
      S_DONE:   state_d = start ? S_HDR_AR : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_q == S_HDR_AR) || (state_q == S_HDR_R) ||
                    (state_q == S_PKT_AR) || (state_q == S_PKT_R);
    done          = (state_q == S_DONE);
    m_axi_arvalid = (state_q == S_HDR_AR) || (state_q == S_PKT_AR);
    m_axi_arlen   = (state_q == S_PKT_AR) ? last_cnt_q : 8'd0;
    m_axi_rready  = 1'b0;
    if (state_q == S_HDR_R) m_axi_rready = 1'b1;
    // Stop accepting once the final beat is captured so stray beats never overwrite it.
    else if (state_q == S_PKT_R) m_axi_rready = (!tvalid_q || m_axis_tready) && !rcvd_all_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      pkt_bytes_q <= '0;
      last_cnt_q  <= '0;
      cnt_q       <= '0;
      rcvd_all_q  <= 1'b0;
      err_q       <= 1'b0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
    end else begin
      if (start_ok) begin
        addr_q      <= {pkt_addr[ADDR_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};
        err_q       <= 1'b0;
        pkt_bytes_q <= '0;
      end
      if (state_q == S_HDR_R && m_axi_rvalid) begin
        pkt_bytes_q <= hdr_bytes[15:0];
        last_cnt_q  <= hdr_beats[7:0] - 8'd1;
        err_q       <= hdr_reject;
        cnt_q       <= '0;
        rcvd_all_q  <= 1'b0;
      end
      if (pkt_r_hs) begin
        tdata_q    <= m_axi_rdata;
        tkeep_q    <= is_last_beat ? keep_last : KEEP_ONES;
        tlast_q    <= is_last_beat;
        cnt_q      <= cnt_q + 8'd1;
        rcvd_all_q <= is_last_beat;
        if (m_axi_rresp != 2'b00 || m_axi_rlast != is_last_beat) err_q <= 1'b1;
      end
      if (pkt_r_hs)  tvalid_q <= 1'b1;
      else if (t_hs) tvalid_q <= 1'b0;
    end
  end

  assign err           = err_q;
  assign pkt_bytes     = pkt_bytes_q;
  assign m_axi_arid    = '0;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arsize  = 3'(OFF_BITS);
  assign m_axi_arburst = 2'b01;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
endmodule

// File: tb/tb_axi4_to_axis_ipv4_reader.sv
// Bench for axi4_to_axis_ipv4_reader: AXI4 slave memory model plus a stream scoreboard.
// Inputs change 1 time unit after the rising edge; handshakes and outputs are sampled on the falling edge.
module tb_axi4_to_axis_ipv4_reader;
  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [31:0]  pkt_addr;
  logic         busy, done, err;
  logic [15:0]  pkt_bytes;
  logic [3:0]   m_axi_arid, m_axi_rid;
  logic [31:0]  m_axi_araddr;
  logic [7:0]   m_axi_arlen;
  logic [2:0]   m_axi_arsize;
  logic [1:0]   m_axi_arburst, m_axi_rresp;
  logic         m_axi_arvalid, m_axi_arready;
  logic [511:0] m_axi_rdata, m_axis_tdata;
  logic         m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [63:0]  m_axis_tkeep;
  logic         m_axis_tvalid, m_axis_tready, m_axis_tlast;

  int checks = 0, failures = 0;
  logic [511:0] mem [int unsigned];
  logic [39:0]  exp_ar_q [$];
  beat_t        exp_t_q [$];

  bit gap_mode = 0;
  int slverr_beat = -1, pkt_burst = -1, burst_no = 0, t_count = 0;

  always #5 clk = ~clk;

  axi4_to_axis_ipv4_reader dut (
    .clk(clk), .rst(rst), .start(start), .pkt_addr(pkt_addr),
    .busy(busy), .done(done), .err(err), .pkt_bytes(pkt_bytes),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
  );

  task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Slave memory model, stream sink and scoreboard in one loop.
  initial begin
    bit ar_hs, r_hs, r_act = 0, stall_pend = 0;
    int r_beat = 0, r_len = 0;
    int unsigned r_base = 0, cap_addr = 0, cap_len = 0;
    beat_t stall_beat, e;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = 0;
    m_axi_rlast = 0; m_axi_rid = 0; m_axis_tready = 0;
    forever begin
      @(negedge clk);
      ar_hs = !rst && m_axi_arvalid && m_axi_arready;
      r_hs  = !rst && m_axi_rvalid && m_axi_rready;
      if (!rst) begin
        if (ar_hs) begin
          cap_addr = m_axi_araddr;
          cap_len  = m_axi_arlen;
          check("ar_const", {m_axi_arid, m_axi_arsize, m_axi_arburst}, {4'd0, 3'd6, 2'b01});
          if (exp_ar_q.size() == 0) check("ar_unexpected", 1, 0);
          else check("ar_addr_len", {m_axi_araddr, m_axi_arlen}, exp_ar_q.pop_front());
        end
        if (stall_pend && m_axis_tvalid)
          check("t_stall_stable", {m_axis_tdata, m_axis_tkeep, m_axis_tlast}, stall_beat);
        stall_pend = m_axis_tvalid && !m_axis_tready;
        stall_beat = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
        if (m_axis_tvalid && m_axis_tready) begin
          t_count++;
          if (exp_t_q.size() == 0) check("t_unexpected", 1, 0);
          else begin
            e = exp_t_q.pop_front();
            check("t_data", m_axis_tdata, e.data);
            check("t_keep", m_axis_tkeep, e.keep);
            check("t_last", m_axis_tlast, e.last);
          end
        end
      end else stall_pend = 0;
      @(posedge clk); #1;
      if (rst) begin
        r_act = 0; m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0; m_axis_tready = 0;
      end else begin
        if (r_hs) begin
          r_beat++;
          if (r_beat > r_len) r_act = 0;
        end
        if (ar_hs) begin
          r_act = 1; r_base = cap_addr >> 6; r_len = int'(cap_len); r_beat = 0; burst_no++;
        end
        m_axi_arready = gap_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (!(m_axi_rvalid && !r_hs)) begin
          if (r_act && (!gap_mode || $urandom_range(0, 2) != 0)) begin
            m_axi_rvalid = 1;
            m_axi_rdata  = mem[r_base + r_beat];
            m_axi_rlast  = (r_beat == r_len);
            m_axi_rresp  = (burst_no == pkt_burst && r_beat == slverr_beat) ? 2'b10 : 2'b00;
          end else begin
            m_axi_rvalid = 0;
            m_axi_rlast  = 0;
          end
        end
        m_axis_tready = gap_mode ? ($urandom_range(0, 2) == 0) : 1'b1;
      end
    end
  end

  // Store a frame in memory and push the expected AR requests and stream beats.
  task automatic load_expect(input logic [31:0] addr, input int tl, output bit reject);
    int bytes = tl + 14;
    int beats = (bytes + 63) / 64;
    int r = bytes % 64;
    logic [511:0] b;
    logic [63:0] last_keep;
    reject = (tl < 20) || (beats > 32);
    last_keep = (r == 0) ? '1 : ((64'd1 << r) - 64'd1);
    for (int i = 0; i < beats; i++) begin
      for (int w = 0; w < 16; w++) b[32*w +: 32] = $urandom;
      if (i == 0) begin
        b[8*16 +: 8] = tl[15:8];
        b[8*17 +: 8] = tl[7:0];
      end
      mem[(addr >> 6) + i] = b;
      if (!reject) exp_t_q.push_back({b, (i == beats - 1) ? last_keep : 64'hFFFF_FFFF_FFFF_FFFF, i == beats - 1});
    end
    exp_ar_q.push_back({addr, 8'd0});
    if (!reject) exp_ar_q.push_back({addr, 8'(beats - 1)});
  endtask

  task automatic pulse_start(input logic [31:0] addr);
    pkt_burst = burst_no + 2;
    @(posedge clk); #1;
    start = 1; pkt_addr = addr;
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    check("busy_after_start", busy, 1);
  endtask

  task automatic run_frame(input logic [31:0] addr, input int tl, input int err_beat);
    bit reject;
    int n = 0;
    slverr_beat = err_beat;
    load_expect(addr, tl, reject);
    pulse_start(addr);
    while (!done && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done, 1);
    check("done_err", err, reject || err_beat >= 0);
    check("done_busy_low", busy, 0);
    if (!reject) check("pkt_bytes", pkt_bytes, 16'(tl + 14));
    @(negedge clk);
    check("done_pulse_1cyc", done, 0);
    check("ar_q_drained", exp_ar_q.size(), 0);
    check("t_q_drained", exp_t_q.size(), 0);
  endtask

  initial begin
    bit reject;
    int n;
    rst = 1; start = 0; pkt_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_ctl", {busy, done, err, m_axi_arvalid, m_axi_rready, m_axis_tvalid, m_axis_tlast}, 0);
    check("rst_data", {m_axis_tdata, m_axis_tkeep, pkt_bytes, m_axi_araddr, m_axi_arlen}, 0);
    check("rst_const", {m_axi_arid, m_axi_arsize, m_axi_arburst}, {4'd0, 3'd6, 2'b01});
    rst = 0;
    repeat (2) @(negedge clk);

    run_frame(32'h0000_1000, 46, -1);     // single beat, 60 bytes
    run_frame(32'h0000_2000, 1500, -1);   // 24 beats, tail 42 bytes
    gap_mode = 1;
    run_frame(32'h0000_3000, 1500, -1);   // stalls on both sides
    gap_mode = 0;
    run_frame(32'h0000_4000, 2034, -1);   // exactly MAX_BEATS, full last beat
    run_frame(32'h0000_5000, 2035, -1);   // one byte too many -> reject
    run_frame(32'h0000_6000, 10, -1);     // below minimum IPv4 length
    run_frame(32'h0000_7000, 1500, 5);    // SLVERR mid-burst, still fully streamed
    run_frame(32'h0000_5800, 19, -1);     // just under minimum
    run_frame(32'h0000_8000, 20, -1);     // minimum accepted

    // Reset in the middle of a packet burst, then a clean frame.
    slverr_beat = -1;
    load_expect(32'h0000_9000, 1500, reject);
    pulse_start(32'h0000_9000);
    n = 0;
    t_count = 0;
    while (t_count < 10 && n < 2000) begin
      @(negedge clk); #2;
      n++;
    end
    check("mid_burst_reached", t_count >= 10, 1);
    check("mid_burst_busy", busy, 1);
    rst = 1;
    @(negedge clk);
    check("rst_mid_burst", {m_axis_tvalid, m_axi_arvalid, m_axi_rready, busy, done}, 0);
    exp_ar_q.delete();
    exp_t_q.delete();
    @(negedge clk); #2;
    rst = 0;
    repeat (2) @(negedge clk);
    run_frame(32'h0000_A000, 300, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
